// File: rtl/fsic_ram128_fifo.sv
// AXI-Stream FIFO on one single-port RAM128 macro.
// Arbitrates the RAM port between writes and prefetch reads into a 2-deep obuf.
module fsic_ram128_fifo #(
  parameter int WSIZE = 4,
  parameter int AW    = 7
) (
  input  logic                 axi_clk,
  input  logic                 axi_reset_n,
  input  logic [WSIZE*8-1:0]   s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [WSIZE*8-1:0]   m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 ram_en,
  output logic [WSIZE-1:0]     ram_we,
  output logic [AW-1:0]        ram_a,
  output logic [WSIZE*8-1:0]   ram_di,
  input  logic [WSIZE*8-1:0]   ram_do,
  output logic [AW:0]          level,
  output logic                 full,
  output logic                 empty
);

  localparam int DW = WSIZE * 8;

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   ram_cnt;
  logic          rd_inflight;
  logic [DW-1:0] ob0;
  logic [DW-1:0] ob1;
  logic [1:0]    ob_cnt;
  logic          last_grant;
  logic          rdy_en;

  logic [1:0] pend;
  logic       rd_want;
  logic       read_slot;
  logic       wr_go;
  logic       rd_go;
  logic       push;
  logic       pop;

  // pend counts obuf words plus the one a read in flight will deliver
  assign pend      = ob_cnt + {1'b0, rd_inflight};
  assign rd_want   = (ram_cnt != '0) && (pend < 2'd2);
  assign read_slot = rd_want && ((pend == 2'd0) || last_grant);

  // depth is exactly 2^AW, so the MSB of the count is the full flag
  assign full     = ram_cnt[AW];
  assign s_tready = rdy_en && !full && !read_slot;
  assign wr_go    = s_tvalid && s_tready;
  assign rd_go    = rd_want && !wr_go;

  assign ram_en = wr_go || rd_go;
  assign ram_we = {WSIZE{wr_go}};
  assign ram_di = s_tdata;

  always_comb begin
    ram_a = '0;
    unique case (1'b1)
      wr_go:   ram_a = wptr;
      rd_go:   ram_a = rptr;
      default: ram_a = '0;
    endcase
  end

  assign level = ram_cnt + {{(AW-1){1'b0}}, pend};
  assign empty = (level == '0);

  assign m_tvalid = (ob_cnt != 2'd0);
  assign m_tdata  = ob0;
  assign push     = rd_inflight;
  assign pop      = m_tvalid && m_tready;

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      rd_inflight <= 1'b0;
      last_grant  <= 1'b0;
      rdy_en      <= 1'b0;
    end else begin
      rdy_en      <= 1'b1;
      rd_inflight <= rd_go;
      if (wr_go) begin
        wptr       <= wptr + AW'(1);
        ram_cnt    <= ram_cnt + (AW+1)'(1);
        last_grant <= 1'b1;
      end else if (rd_go) begin
        rptr       <= rptr + AW'(1);
        ram_cnt    <= ram_cnt - (AW+1)'(1);
        last_grant <= 1'b0;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      ob0    <= '0;
      ob1    <= '0;
      ob_cnt <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (ob_cnt == 2'd0) ob0 <= ram_do;
          else                ob1 <= ram_do;
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b01: begin
          ob0    <= ob1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            ob0 <= ram_do;
          end else begin
            ob0 <= ob1;
            ob1 <= ram_do;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fsic_ram128_fifo.sv
// Directed and random bench for fsic_ram128_fifo.
// Includes a behavioural RAM128 with 1-cycle synchronous read.
module tb_fsic_ram128_fifo;

  logic        axi_clk = 1'b0;
  logic        axi_reset_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [6:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do = '0;
  logic [7:0]  level;
  logic        full;
  logic        empty;

  int n_chk = 0;
  int n_fail = 0;

  fsic_ram128_fifo dut (
    .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a),
    .ram_di(ram_di), .ram_do(ram_do),
    .level(level), .full(full), .empty(empty)
  );

  always #5 axi_clk = ~axi_clk;

  logic [31:0] mem [128];
  always @(posedge axi_clk) begin
    if (ram_en) begin
      if (ram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (ram_we[b]) mem[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
      end else begin
        ram_do <= mem[ram_a];
      end
    end
  end

  logic [31:0] q [$];
  logic        acc, popd, en_s, st_s, mv_s, full_s, emp_s;
  logic [3:0]  we_s;
  logic [6:0]  a_s;
  logic [7:0]  lvl_s;
  logic [31:0] odata, exp_s;
  int          qsz_s;

  task automatic cyc(input logic sv, input logic [31:0] sd, input logic mr);
    @(negedge axi_clk);
    s_tvalid = sv;
    s_tdata  = sd;
    m_tready = mr;
    #1;
    acc = sv && s_tready;
    popd = m_tvalid && mr;
    odata = m_tdata;
    en_s = ram_en; we_s = ram_we; a_s = ram_a;
    st_s = s_tready; mv_s = m_tvalid;
    lvl_s = level; full_s = full; emp_s = empty;
    qsz_s = q.size();
    if (acc) q.push_back(sd);
    exp_s = 32'hDEAD_BEEF;
    if (popd && q.size() != 0) exp_s = q.pop_front();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 32'h7000_0000 + i, 1'b0);
    @(negedge axi_clk);
    #2 axi_reset_n = 1'b0;
    #1;
    n_chk++;
    if ({s_tready, m_tvalid, ram_en, full, empty} !== 5'b00001) begin
      n_fail++;
      $display("FAIL rst_flags: got %b expected 00001",
               {s_tready, m_tvalid, ram_en, full, empty});
    end
    n_chk++;
    if (m_tdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_mtdata: got %h expected 0", m_tdata);
    end
    n_chk++;
    if (ram_we !== 4'h0 || ram_a !== 7'h0) begin
      n_fail++;
      $display("FAIL rst_ram: got we=%h a=%h expected 0/0", ram_we, ram_a);
    end
    n_chk++;
    if (level !== 8'd0) begin
      n_fail++; $display("FAIL rst_level: got %0d expected 0", level);
    end
    q.delete();
    repeat (2) @(negedge axi_clk);
    #2 axi_reset_n = 1'b1;
    #1;
    n_chk++;
    if (s_tready !== 1'b0) begin
      n_fail++; $display("FAIL rdy_edge1: got %b expected 0", s_tready);
    end
    @(posedge axi_clk);
    #1;
    n_chk++;
    if (s_tready !== 1'b1) begin
      n_fail++; $display("FAIL rdy_edge2: got %b expected 1", s_tready);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic test_single();
    cyc(1'b1, 32'hA5A5_0001, 1'b1);
    n_chk++;
    if ({acc, en_s, we_s, a_s} !== {1'b1, 1'b1, 4'hF, 7'd0}) begin
      n_fail++;
      $display("FAIL single_wr: got acc=%b en=%b we=%h a=%0d expected 1 1 F 0",
               acc, en_s, we_s, a_s);
    end
    cyc(1'b0, 32'h0, 1'b1);
    n_chk++;
    if ({en_s, we_s, a_s} !== {1'b1, 4'h0, 7'd0}) begin
      n_fail++;
      $display("FAIL single_rd: got en=%b we=%h a=%0d expected 1 0 0",
               en_s, we_s, a_s);
    end
    cyc(1'b0, 32'h0, 1'b1);
    n_chk++;
    if (mv_s !== 1'b0) begin
      n_fail++; $display("FAIL single_early: got mvalid=%b expected 0", mv_s);
    end
    cyc(1'b0, 32'h0, 1'b1);
    n_chk++;
    if (mv_s !== 1'b1 || odata !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_out: got v=%b d=%h expected 1 a5a50001",
               mv_s, odata);
    end
    cyc(1'b0, 32'h0, 1'b1);
    n_chk++;
    if (lvl_s !== 8'd0 || emp_s !== 1'b1) begin
      n_fail++;
      $display("FAIL single_lvl: got level=%0d empty=%b expected 0 1",
               lvl_s, emp_s);
    end
  endtask

  task automatic test_fill();
    int i = 0;
    int k = 0;
    while (i < 130 && k < 1000) begin
      cyc(1'b1, 32'h1000_0000 + i, 1'b0);
      if (acc) i++;
      k++;
    end
    n_chk++;
    if (i != 130) begin
      n_fail++; $display("FAIL fill_budget: got %0d words expected 130", i);
    end
    for (int j = 0; j < 4; j++) begin
      cyc(1'b1, 32'h1000_0000 + 130, 1'b0);
      n_chk++;
      if (acc !== 1'b0) begin
        n_fail++; $display("FAIL fill_131: got accept=%b expected 0", acc);
      end
    end
    n_chk++;
    if ({full_s, st_s} !== 2'b10 || lvl_s !== 8'd130) begin
      n_fail++;
      $display("FAIL fill_state: got full=%b rdy=%b level=%0d expected 1 0 130",
               full_s, st_s, lvl_s);
    end
    n_chk++;
    if (mv_s !== 1'b1 || odata !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL fill_head: got v=%b d=%h expected 1 10000000", mv_s, odata);
    end
  endtask

  task automatic test_drain();
    int j = 0;
    int k = 0;
    bit seen = 0;
    bit chk_next = 0;
    while (j < 130 && k < 1000) begin
      cyc(1'b0, 32'h0, 1'b1);
      k++;
      if (chk_next) begin
        chk_next = 0;
        n_chk++;
        if (st_s !== 1'b1) begin
          n_fail++; $display("FAIL drain_rdy: got %b expected 1", st_s);
        end
      end
      if (!seen && en_s && we_s == 4'h0) begin
        seen = 1; chk_next = 1;
        n_chk++;
        if (st_s !== 1'b0) begin
          n_fail++; $display("FAIL drain_full_rdy: got %b expected 0", st_s);
        end
      end
      if (popd) begin
        n_chk++;
        if (odata !== 32'h1000_0000 + j) begin
          n_fail++;
          $display("FAIL drain_data[%0d]: got %h expected %h",
                   j, odata, 32'h1000_0000 + j);
        end
        j++;
      end
    end
    n_chk++;
    if (j != 130 || !seen) begin
      n_fail++;
      $display("FAIL drain_count: got %0d words seen_rd=%0d expected 130 1", j, seen);
    end
    cyc(1'b0, 32'h0, 1'b1);
    n_chk++;
    if (emp_s !== 1'b1 || lvl_s !== 8'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got empty=%b level=%0d expected 1 0", emp_s, lvl_s);
    end
  endtask

  task automatic test_back_to_back();
    int na = 0;
    int e = 0;
    int c = 0;
    logic [3:0] prev_we = 4'h0;
    while (na < 1000 && c < 4000) begin
      cyc(1'b1, 32'hB000_0000 + na, 1'b1);
      if (acc) na++;
      if (popd) begin
        n_chk++;
        if (odata !== 32'hB000_0000 + e) begin
          n_fail++;
          $display("FAIL b2b_data[%0d]: got %h expected %h",
                   e, odata, 32'hB000_0000 + e);
        end
        e++;
      end
      if (c >= 10) begin
        n_chk++;
        if (en_s !== 1'b1 || we_s === prev_we) begin
          n_fail++;
          $display("FAIL b2b_alt: got en=%b we=%h prev_we=%h expected alternating",
                   en_s, we_s, prev_we);
        end
      end
      prev_we = we_s;
      c++;
    end
    c = 0;
    while (e < na && c < 100) begin
      cyc(1'b0, 32'h0, 1'b1);
      if (popd) begin
        n_chk++;
        if (odata !== 32'hB000_0000 + e) begin
          n_fail++;
          $display("FAIL b2b_tail[%0d]: got %h expected %h",
                   e, odata, 32'hB000_0000 + e);
        end
        e++;
      end
      c++;
    end
    n_chk++;
    if (na != 1000 || e != 1000) begin
      n_fail++;
      $display("FAIL b2b_count: got in=%0d out=%0d expected 1000 1000", na, e);
    end
  endtask

  task automatic test_random();
    int na = 0;
    int c = 0;
    while ((na < 10000 || q.size() != 0) && c < 50000) begin
      cyc(na < 10000 && $urandom_range(0, 3) != 0, $urandom,
          $urandom_range(0, 3) != 0);
      if (acc) na++;
      n_chk++;
      if (lvl_s !== 8'(qsz_s)) begin
        n_fail++; $display("FAIL rnd_level: got %0d expected %0d", lvl_s, qsz_s);
      end
      n_chk++;
      if (we_s !== 4'h0 && we_s !== 4'hF) begin
        n_fail++; $display("FAIL rnd_we: got %h expected 0 or F", we_s);
      end
      if (popd) begin
        n_chk++;
        if (odata !== exp_s) begin
          n_fail++; $display("FAIL rnd_data: got %h expected %h", odata, exp_s);
        end
      end
      c++;
    end
    n_chk++;
    if (na != 10000 || q.size() != 0) begin
      n_fail++;
      $display("FAIL rnd_budget: got in=%0d left=%0d expected 10000 0", na, q.size());
    end
  endtask

  initial begin
    repeat (2) @(negedge axi_clk);
    axi_reset_n = 1'b1;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
